elevator_dispatcher: RTL

Request side of the elevator car controller. Latches hall calls and cab requests for a 10-floor building, then picks the next target floor with a SCAN (sweep) policy. The target is driven on O_DEST_FLOOR into the car FSM, and I_CUR_FLOOR / I_CAR_IDLE are read back from it. Also owns the door: the door opens only when the car is idle at a served floor, and is forced closed during emergency.

---
 rtl/elevator_dispatcher.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/elevator_dispatcher.sv
// SCAN-policy request dispatcher and door owner for the elevator car controller.
// Optional build macro DOOR_HOLD_EN adds I_DOOR_HOLD to keep the door open while held.
module elevator_dispatcher #(
   parameter int NUM_FLOORS  = 10,
   parameter int FLOOR_W     = 4,
   parameter int DOOR_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NUM_FLOORS-1:0] I_HALL_CALL,
   input  logic [NUM_FLOORS-1:0] I_CAB_REQ,
   input  logic [FLOOR_W-1:0]    I_CUR_FLOOR,
   input  logic                  I_CAR_IDLE,
   input  logic                  I_EMERGENCY,
   input  logic                  I_EMER_RESOLVE,
`ifdef DOOR_HOLD_EN
   input  logic                  I_DOOR_HOLD,
`endif
   output logic [FLOOR_W-1:0]    O_DEST_FLOOR,
   output logic                  O_DOOR_OPEN,
   output logic [NUM_FLOORS-1:0] O_PENDING,
   output logic                  O_DIR_UP
);

   localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {ST_WAIT, ST_SERVE, ST_DOOR, ST_HALT} state_t;

   state_t                r_state;
   logic [NUM_FLOORS-1:0] r_pending;
   logic [FLOOR_W-1:0]    r_dest;
   logic                  r_door_open;
   logic                  r_dir_up;
   logic [CNT_W-1:0]      r_door_cnt;

   state_t                w_state_next;
   logic [FLOOR_W-1:0]    w_dest_next;
   logic                  w_dir_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [NUM_FLOORS-1:0] w_clr;

   logic                  w_cur_valid;
   logic [NUM_FLOORS-1:0] w_cur_hot;
   logic [NUM_FLOORS-1:0] w_above;
   logic [NUM_FLOORS-1:0] w_below;
   logic                  w_cur_pending;
   logic                  w_at_dest;
   logic                  w_up_found;
   logic                  w_dn_found;
   logic [FLOOR_W-1:0]    w_up_floor;
   logic [FLOOR_W-1:0]    w_dn_floor;

   // An out-of-range floor report matches no floor, so nothing is cleared or served there.
   assign w_cur_valid = int'(I_CUR_FLOOR) < NUM_FLOORS;

   generate
      for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
         assign w_cur_hot[gi] = w_cur_valid && (I_CUR_FLOOR == FLOOR_W'(gi));
         assign w_above[gi]   = r_pending[gi] && (FLOOR_W'(gi) > I_CUR_FLOOR);
         assign w_below[gi]   = r_pending[gi] && (FLOOR_W'(gi) < I_CUR_FLOOR);
      end
   endgenerate

   assign w_cur_pending = |(r_pending & w_cur_hot);
   assign w_at_dest     = w_cur_valid && I_CAR_IDLE && (I_CUR_FLOOR == r_dest);

   // Nearest pending floor on each side of the car.
   always_comb begin
      w_up_found = 1'b0;
      w_up_floor = '0;
      w_dn_found = 1'b0;
      w_dn_floor = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (w_above[i]) begin
            w_up_found = 1'b1;
            w_up_floor = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (w_below[i]) begin
            w_dn_found = 1'b1;
            w_dn_floor = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_dest_next  = r_dest;
      w_dir_next   = r_dir_up;
      w_cnt_next   = r_door_cnt;
      w_clr        = '0;
      case (r_state)
         ST_WAIT: begin
            w_dest_next = I_CUR_FLOOR;
            if (I_CAR_IDLE && w_cur_pending) begin
               w_state_next = ST_DOOR;
               w_clr        = w_cur_hot;
               w_cnt_next   = CNT_LOAD;
            end else if (r_dir_up) begin
               if (w_up_found) begin
                  w_state_next = ST_SERVE;
                  w_dest_next  = w_up_floor;
               end else if (w_dn_found) begin
                  w_state_next = ST_SERVE;
                  w_dest_next  = w_dn_floor;
                  w_dir_next   = 1'b0;
               end
            end else begin
               if (w_dn_found) begin
                  w_state_next = ST_SERVE;
                  w_dest_next  = w_dn_floor;
               end else if (w_up_found) begin
                  w_state_next = ST_SERVE;
                  w_dest_next  = w_up_floor;
                  w_dir_next   = 1'b1;
               end
            end
         end
         ST_SERVE: begin
            if (w_at_dest) begin
               w_state_next = ST_DOOR;
               w_clr        = w_cur_hot;
               w_cnt_next   = CNT_LOAD;
            end
         end
         ST_DOOR: begin
            // Requests for the floor being served are absorbed while the door is open.
            w_clr = w_cur_hot;
`ifdef DOOR_HOLD_EN
            if (I_DOOR_HOLD) begin
               w_cnt_next = CNT_LOAD;
            end else
`endif
            if (r_door_cnt == '0) begin
               w_state_next = ST_WAIT;
            end else begin
               w_cnt_next = r_door_cnt - 1'b1;
            end
         end
         ST_HALT: begin
            w_dest_next = I_CUR_FLOOR;
            if (I_EMER_RESOLVE) begin
               w_state_next = ST_WAIT;
            end
         end
         default: w_state_next = ST_WAIT;
      endcase
      if (I_EMERGENCY) begin
         w_state_next = ST_HALT;
         w_dest_next  = I_CUR_FLOOR;
         w_dir_next   = r_dir_up;
         w_cnt_next   = '0;
         w_clr        = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= ST_WAIT;
         r_pending   <= '0;
         r_dest      <= '0;
         r_door_open <= 1'b0;
         r_dir_up    <= 1'b1;
         r_door_cnt  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_pending   <= (r_pending | I_HALL_CALL | I_CAB_REQ) & ~w_clr;
         r_dest      <= w_dest_next;
         r_door_open <= (w_state_next == ST_DOOR);
         r_dir_up    <= w_dir_next;
         r_door_cnt  <= w_cnt_next;
      end
   end

   assign O_DEST_FLOOR = r_dest;
   assign O_DOOR_OPEN  = r_door_open;
   assign O_PENDING    = r_pending;
   assign O_DIR_UP     = r_dir_up;

endmodule
